// File: rtl/mannix_mem_pkg.sv
// rtl/mannix_mem_pkg.sv - shared memory-side constants and read arbiter state type
package mannix_mem_pkg;

  localparam int ADDR_WIDTH      = 19;
  localparam int MEM_DATA_BUS    = 128;
  localparam int MAX_BYTES_TO_RD = 20;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_DATA = 2'b10,
    RESP      = 2'b11
  } arb_state_t;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// rtl/mem_rd_arbiter_if.sv - memory read port between arbiter and memory controller
interface mem_rd_arbiter_if #(
  parameter int ADDR_WIDTH   = 19,
  parameter int SIZE_WIDTH   = 6,
  parameter int MEM_DATA_BUS = 128
) ();

  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_start_addr;
  logic [SIZE_WIDTH-1:0]   mem_size_bytes;
  logic                    mem_gnt;
  logic                    mem_valid;
  logic [MEM_DATA_BUS-1:0] mem_data;

  modport master (
    output mem_req, mem_start_addr, mem_size_bytes,
    input  mem_gnt, mem_valid, mem_data
  );

  modport slave (
    input  mem_req, mem_start_addr, mem_size_bytes,
    output mem_gnt, mem_valid, mem_data
  );

endinterface

// File: rtl/mem_rd_arbiter_rr_pick.sv
// rtl/mem_rd_arbiter_rr_pick.sv - combinational round-robin picker starting after rr_last
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             sel;
  int             c;

  // Rotate so bit 0 is the client right after rr_last, take the lowest set bit, map back.
  always_comb begin
    dbl = {eligible, eligible};
    rot = N'(dbl >> (int'(rr_last) + 1));
    sel = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) sel = j;
    end
    c = int'(rr_last) + 1 + sel;
    if (c >= N) c = c - N;
    any = |eligible;
    gnt = any ? (N'(1) << c) : '0;
    idx = IW'(c);
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - round-robin single-outstanding memory read arbiter
module mem_rd_arbiter #(
  parameter int NUM_CLIENTS     = 2,
  parameter int ADDR_WIDTH      = mannix_mem_pkg::ADDR_WIDTH,
  parameter int MEM_DATA_BUS    = mannix_mem_pkg::MEM_DATA_BUS,
  parameter int MAX_BYTES_TO_RD = mannix_mem_pkg::MAX_BYTES_TO_RD,
  parameter int SIZE_WIDTH      = $clog2(MAX_BYTES_TO_RD) + 1,
  parameter int CL_IDX_W        = $clog2(NUM_CLIENTS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            cl_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_start_addr,
  input  logic [NUM_CLIENTS*SIZE_WIDTH-1:0] cl_size_bytes,
  output logic [NUM_CLIENTS-1:0]            cl_gnt,
  output logic [NUM_CLIENTS-1:0]            cl_valid,
  output logic [MEM_DATA_BUS-1:0]           cl_data,
  mem_rd_arbiter_if.master                  mem,
  output logic                              arb_busy,
  output logic [CL_IDX_W-1:0]               arb_cur_client,
  output logic                              arb_err
);

  import mannix_mem_pkg::arb_state_t;
  import mannix_mem_pkg::IDLE;
  import mannix_mem_pkg::ISSUE;
  import mannix_mem_pkg::WAIT_DATA;
  import mannix_mem_pkg::RESP;

  arb_state_t                state_q, state_d;
  logic                      req_q, req_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [SIZE_WIDTH-1:0]     size_q, size_d;
  logic [NUM_CLIENTS-1:0]    gnt_d, valid_d;
  logic [MEM_DATA_BUS-1:0]   data_d;
  logic [CL_IDX_W-1:0]       cur_d;
  logic [CL_IDX_W-1:0]       rr_last_q, rr_last_d;
  logic [NUM_CLIENTS-1:0]    served_q, served_d;
  logic                      err_d;

  logic [NUM_CLIENTS-1:0]    pick_gnt;
  logic [CL_IDX_W-1:0]       pick_idx;
  logic                      pick_any;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [SIZE_WIDTH-1:0]     sel_size;
  logic                      sel_size_bad;

  assign mem.mem_req        = req_q;
  assign mem.mem_start_addr = addr_q;
  assign mem.mem_size_bytes = size_q;

  rr_pick #(.N(NUM_CLIENTS), .IW(CL_IDX_W)) u_pick (
    .eligible (cl_req & ~served_q),
    .rr_last  (rr_last_q),
    .gnt      (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // One-hot mux of the picked client's address and size.
  always_comb begin
    sel_addr = '0;
    sel_size = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (pick_gnt[k]) begin
        sel_addr = cl_start_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size = cl_size_bytes[k*SIZE_WIDTH +: SIZE_WIDTH];
      end
    end
    sel_size_bad = (sel_size == '0) || (sel_size > SIZE_WIDTH'(MAX_BYTES_TO_RD));
  end

  // Next-state and next-output logic; pulses default low, held values default to current.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    size_d    = size_q;
    gnt_d     = '0;
    valid_d   = '0;
    data_d    = cl_data;
    cur_d     = arb_cur_client;
    rr_last_d = rr_last_q;
    served_d  = served_q;
    err_d     = arb_err;

    if (mem.mem_gnt && state_q != ISSUE) err_d = 1'b1;
    if (mem.mem_valid && (state_q == IDLE || state_q == RESP)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          addr_d  = sel_addr;
          size_d  = sel_size;
          cur_d   = pick_idx;
          req_d   = 1'b1;
          state_d = ISSUE;
          if (sel_size_bad) err_d = 1'b1;
        end
      end
      ISSUE: begin
        if (mem.mem_gnt) begin
          req_d = 1'b0;
          gnt_d = NUM_CLIENTS'(1) << arb_cur_client;
          if (mem.mem_valid) begin
            data_d  = mem.mem_data;
            valid_d = NUM_CLIENTS'(1) << arb_cur_client;
            state_d = RESP;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (mem.mem_valid) begin
          data_d  = mem.mem_data;
          valid_d = NUM_CLIENTS'(1) << arb_cur_client;
          state_d = RESP;
        end
      end
      RESP: begin
        rr_last_d = arb_cur_client;
        served_d  = served_q | (NUM_CLIENTS'(1) << arb_cur_client);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A client is re-armed by any cycle with its request low.
    served_d = served_d & cl_req;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_q          <= 1'b0;
      addr_q         <= '0;
      size_q         <= '0;
      cl_gnt         <= '0;
      cl_valid       <= '0;
      cl_data        <= '0;
      arb_cur_client <= '0;
      rr_last_q      <= CL_IDX_W'(NUM_CLIENTS - 1);
      served_q       <= '0;
      arb_err        <= 1'b0;
      arb_busy       <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      cl_gnt         <= gnt_d;
      cl_valid       <= valid_d;
      cl_data        <= data_d;
      arb_cur_client <= cur_d;
      rr_last_q      <= rr_last_d;
      served_q       <= served_d;
      arb_err        <= err_d;
      arb_busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb/tb_mem_rd_arbiter.sv - self-checking bench for mem_rd_arbiter
module tb_mem_rd_arbiter;

  localparam int N    = 2;
  localparam int AW   = 19;
  localparam int DW   = 128;
  localparam int MAXB = 20;
  localparam int SW   = 6;
  localparam int IW   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    cl_req;
  logic [N*AW-1:0] cl_start_addr;
  logic [N*SW-1:0] cl_size_bytes;
  logic [N-1:0]    cl_gnt, cl_valid;
  logic [DW-1:0]   cl_data;
  logic            arb_busy;
  logic [IW-1:0]   arb_cur_client;
  logic            arb_err;

  mem_rd_arbiter_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .MEM_DATA_BUS(DW)) mem_if ();

  mem_rd_arbiter #(
    .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .MEM_DATA_BUS(DW), .MAX_BYTES_TO_RD(MAXB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cl_req         (cl_req),
    .cl_start_addr  (cl_start_addr),
    .cl_size_bytes  (cl_size_bytes),
    .cl_gnt         (cl_gnt),
    .cl_valid       (cl_valid),
    .cl_data        (cl_data),
    .mem            (mem_if.master),
    .arb_busy       (arb_busy),
    .arb_cur_client (arb_cur_client),
    .arb_err        (arb_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int gnt_cnt = 0;
  int valid_cnt = 0;
  int gnt_order[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event within cycle budget, required one", nm);
  endtask

  // Transaction-level reference: a job is picked by scanning forward from the last served
  // client, waits for the memory grant, waits for data, then is delivered for one cycle.
  int              m_phase;   // 0 free, 1 awaiting grant, 2 awaiting data, 3 delivering
  int              m_owner;
  int              m_last;
  logic [N-1:0]    m_blocked;
  int              m_win;
  logic [AW-1:0]   m_a;
  logic [SW-1:0]   m_s;
  logic            e_req, e_busy, e_err;
  logic [AW-1:0]   e_addr;
  logic [SW-1:0]   e_size;
  logic [N-1:0]    e_gnt, e_valid;
  logic [DW-1:0]   e_data;
  logic [IW-1:0]   e_cur;
  bit              started = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_last = N - 1; m_blocked = '0;
      e_req = 0; e_addr = 0; e_size = 0; e_gnt = 0; e_valid = 0;
      e_data = 0; e_cur = 0; e_err = 0;
    end else begin
      e_gnt = 0;
      e_valid = 0;
      if (mem_if.mem_valid && (m_phase == 0 || m_phase == 3)) e_err = 1;
      if (mem_if.mem_gnt && m_phase != 1) e_err = 1;
      if (m_phase == 0) begin
        m_win = -1;
        for (int off = N; off >= 1; off--) begin
          if (cl_req[(m_last + off) % N] && !m_blocked[(m_last + off) % N]) m_win = (m_last + off) % N;
        end
        if (m_win >= 0) begin
          m_a = cl_start_addr[m_win*AW +: AW];
          m_s = cl_size_bytes[m_win*SW +: SW];
          e_addr = m_a; e_size = m_s; e_req = 1; e_cur = IW'(m_win);
          m_owner = m_win;
          if (m_s == 0 || int'(m_s) > MAXB) e_err = 1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (mem_if.mem_gnt) begin
          e_req = 0;
          e_gnt[m_owner] = 1;
          if (mem_if.mem_valid) begin
            e_data = mem_if.mem_data; e_valid[m_owner] = 1; m_phase = 3;
          end else m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (mem_if.mem_valid) begin
          e_data = mem_if.mem_data; e_valid[m_owner] = 1; m_phase = 3;
        end
      end else begin
        m_last = m_owner;
        m_blocked[m_owner] = 1;
        m_phase = 0;
      end
      m_blocked = m_blocked & cl_req;
    end
    e_busy = (m_phase != 0);
    started = 1;
  end

  // Per-cycle comparison of every DUT output against the reference.
  always @(negedge clk) begin
    if (started) begin
      chk("mem_req", mem_if.mem_req, e_req);
      chk("mem_start_addr", mem_if.mem_start_addr, e_addr);
      chk("mem_size_bytes", mem_if.mem_size_bytes, e_size);
      chk("cl_gnt", cl_gnt, e_gnt);
      chk("cl_valid", cl_valid, e_valid);
      chk("cl_data", cl_data, e_data);
      chk("arb_busy", arb_busy, e_busy);
      chk("arb_cur_client", arb_cur_client, e_cur);
      chk("arb_err", arb_err, e_err);
      if (|cl_gnt) begin
        gnt_cnt++;
        gnt_order.push_back(cl_gnt[1] ? 1 : 0);
      end
      if (|cl_valid) valid_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic set_client(input int k, input logic [AW-1:0] a, input logic [SW-1:0] s);
    cl_start_addr[k*AW +: AW] = a;
    cl_size_bytes[k*SW +: SW] = s;
  endtask

  task automatic wait_req();
    int i = 0;
    while (!mem_if.mem_req && i < 40) begin
      tick();
      i++;
    end
    if (!mem_if.mem_req) timeout("wait_mem_req");
  endtask

  // Plays the memory: grant gd cycles after the request, data vd cycles after the grant
  // (or in the grant cycle when same is set); returns at the cycle cl_valid is seen.
  task automatic run_txn(input int gd, input int vd, input logic [DW-1:0] d, input bit same,
                         output int who, output logic [AW-1:0] a, output logic [SW-1:0] s);
    int i;
    who = -1;
    wait_req();
    a = mem_if.mem_start_addr;
    s = mem_if.mem_size_bytes;
    repeat (gd) tick();
    mem_if.mem_gnt = 1;
    if (same) begin
      mem_if.mem_valid = 1;
      mem_if.mem_data = d;
    end
    tick();
    mem_if.mem_gnt = 0;
    mem_if.mem_valid = 0;
    if (!same) begin
      repeat (vd - 1) tick();
      mem_if.mem_valid = 1;
      mem_if.mem_data = d;
      tick();
      mem_if.mem_valid = 0;
    end
    i = 0;
    while (cl_valid == '0 && i < 10) begin
      tick();
      i++;
    end
    if (cl_valid == '0) timeout("wait_cl_valid");
    else who = cl_valid[1] ? 1 : 0;
  endtask

  int             who;
  logic [AW-1:0]  a;
  logic [SW-1:0]  s;
  int             who_q[4];
  logic [AW-1:0]  addr_q[4];
  int             exp_ord[4] = '{0, 1, 0, 1};
  logic [AW-1:0]  exp_addr[4] = '{19'h200, 19'h300, 19'h200, 19'h300};
  logic [DW-1:0]  d;
  int             cnt0, vcnt0;

  initial begin
    rst_n = 0; cl_req = 0; cl_start_addr = 0; cl_size_bytes = 0;
    mem_if.mem_gnt = 0; mem_if.mem_valid = 0; mem_if.mem_data = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("reset_mem_req", mem_if.mem_req, 0);
    chk("reset_busy", arb_busy, 0);
    chk("reset_err", arb_err, 0);

    // Single client
    set_client(0, 19'h100, 6'd4);
    cl_req = 2'b01;
    run_txn(2, 3, {16{8'hA5}}, 0, who, a, s);
    chk("t1_who", who, 0);
    chk("t1_addr", a, 19'h100);
    chk("t1_size", s, 4);
    chk("t1_data", cl_data, {16{8'hA5}});
    cl_req = 2'b00;
    tick(); tick();
    chk("t1_gnt_pulses", gnt_cnt, 1);
    chk("t1_valid_pulses", valid_cnt, 1);
    chk("t1_idle_after", arb_busy, 0);

    // Both clients, toggle low one cycle after each valid
    do_reset();
    gnt_order.delete();
    set_client(0, 19'h200, 6'd8);
    set_client(1, 19'h300, 6'd16);
    cl_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      d = {96'h0, 32'hC0DE0000 | 32'(t)};
      run_txn(1, 1, d, 0, who, a, s);
      who_q[t] = who;
      addr_q[t] = a;
      chk("t2_data", cl_data, d);
      if (who >= 0) begin
        tick();
        cl_req[who] = 0;
        tick();
        cl_req[who] = 1;
      end
    end
    cl_req = 2'b00;
    tick(); tick();
    for (int t = 0; t < 4; t++) begin
      chk("t2_order", who_q[t], exp_ord[t]);
      chk("t2_addr", addr_q[t], exp_addr[t]);
    end
    chk("t2_gnt_order_len", gnt_order.size(), 4);

    // Client 0 keeps req high after service
    set_client(0, 19'h180, 6'd12);
    cl_req = 2'b01;
    run_txn(0, 2, {4{32'h1234_5678}}, 0, who, a, s);
    chk("t3_who", who, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_no_rereq", mem_if.mem_req, 0);
    end
    cl_req = 2'b00;
    tick();
    cl_req = 2'b01;
    run_txn(1, 1, {4{32'h8765_4321}}, 0, who, a, s);
    chk("t3_rearmed_who", who, 0);
    chk("t3_rearmed_addr", a, 19'h180);
    cl_req = 2'b00;
    tick(); tick();

    // Grant and data in the same cycle, max legal size
    cnt0 = gnt_cnt;
    vcnt0 = valid_cnt;
    set_client(1, 19'h3C0, 6'd20);
    cl_req = 2'b10;
    run_txn(1, 0, {8{16'hBEEF}}, 1, who, a, s);
    chk("t4_who", who, 1);
    chk("t4_data", cl_data, {8{16'hBEEF}});
    cl_req = 2'b00;
    tick(); tick();
    chk("t4_gnt_once", gnt_cnt, cnt0 + 1);
    chk("t4_valid_once", valid_cnt, vcnt0 + 1);
    chk("t4_no_err", arb_err, 0);
    chk("t4_idle", arb_busy, 0);

    // Illegal sizes 0 and 21
    set_client(0, 19'h010, 6'd0);
    cl_req = 2'b01;
    run_txn(1, 1, {DW{1'b1}}, 0, who, a, s);
    chk("t6_size0_who", who, 0);
    chk("t6_size0_fwd", s, 0);
    cl_req = 2'b00;
    tick(); tick();
    chk("t6_size0_err", arb_err, 1);
    do_reset();
    chk("t6_err_cleared", arb_err, 0);
    set_client(1, 19'h020, 6'd21);
    cl_req = 2'b10;
    run_txn(1, 1, {DW{1'b0}}, 0, who, a, s);
    chk("t6_size21_who", who, 1);
    chk("t6_size21_fwd", s, 21);
    cl_req = 2'b00;
    tick(); tick();
    chk("t6_size21_err", arb_err, 1);
    do_reset();

    // Reset in WAIT_DATA, then a stray mem_valid
    set_client(0, 19'h040, 6'd8);
    cl_req = 2'b01;
    wait_req();
    mem_if.mem_gnt = 1;
    tick();
    mem_if.mem_gnt = 0;
    tick();
    chk("t5_busy_wait", arb_busy, 1);
    vcnt0 = valid_cnt;
    cl_req = 2'b00;
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t5_req_dropped", mem_if.mem_req, 0);
    chk("t5_idle", arb_busy, 0);
    tick();
    mem_if.mem_valid = 1;
    mem_if.mem_data = {4{32'hDEAD_0000}};
    tick();
    mem_if.mem_valid = 0;
    chk("t5_err_set", arb_err, 1);
    repeat (4) tick();
    chk("t5_err_sticky", arb_err, 1);
    chk("t5_no_valid", valid_cnt, vcnt0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish within 100000 time units");
    $fatal(1);
  end

endmodule
